// File: rtl/uart_tx_if.sv
// Byte handshake and serial-line bundle between an upstream byte source and uart_tx.
// The master side is the byte producer; the slave side is the transmitter.
interface uart_tx_if;
   logic [7:0] data_tx;
   logic       valid_tx;
   logic       ready_tx;
   logic       tx;
   logic       done_tx;

   modport master (
      output data_tx,
      output valid_tx,
      input  ready_tx,
      input  tx,
      input  done_tx
   );

   modport slave (
      input  data_tx,
      input  valid_tx,
      output ready_tx,
      output tx,
      output done_tx
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, framed as start, 8 data bits (LSB first),
// optional parity and 1 or 2 stop bits, each bit held for DELAY clocks; done_tx pulses at frame end.
module uart_tx #(
   parameter int SYS_CLK   = 25_000_000,
   parameter int BPS       = 9600,
   parameter int DELAY     = SYS_CLK / BPS,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic     clk,
   input  logic     rst,
   uart_tx_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   localparam logic [15:0] CNT_LAST  = 16'(DELAY - 1);
   localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic        stop_idx_q, stop_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        parity_q, parity_d;
   logic        tx_q, tx_d;
   logic        ready_q, ready_d;
   logic        done_q, done_d;
   logic        accept;
   logic        bit_end;

   assign accept  = bus.valid_tx && ready_q;
   assign bit_end = (cnt_q == CNT_LAST);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      shift_d    = shift_q;
      parity_d   = parity_q;
      tx_d       = tx_q;
      done_d     = 1'b0;

      if (state_q != S_IDLE) begin
         cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
      end

      unique case (state_q)
         S_IDLE: begin
            cnt_d      = 16'd0;
            bit_idx_d  = 3'd0;
            stop_idx_d = 1'b0;
            tx_d       = 1'b1;
            // The start bit is driven from the accepting edge so back-to-back frames
            // are separated by a single idle-high clock.
            if (accept) begin
               state_d  = S_START;
               shift_d  = bus.data_tx;
               parity_d = (PARITY == 1) ? ~(^bus.data_tx) : ^bus.data_tx;
               tx_d     = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               tx_d    = shift_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_idx_q == 3'd7) begin
                  if (PARITY != 0) begin
                     state_d = S_PARITY;
                     tx_d    = parity_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               tx_d    = 1'b1;
            end
         end
         S_STOP: begin
            tx_d = 1'b1;
            if (bit_end) begin
               if (stop_idx_q == STOP_LAST) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  stop_idx_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 16'd0;
         bit_idx_q  <= 3'd0;
         stop_idx_q <= 1'b0;
         shift_q    <= 8'd0;
         parity_q   <= 1'b0;
         tx_q       <= 1'b1;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         shift_q    <= shift_d;
         parity_q   <= parity_d;
         tx_q       <= tx_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
      end
   end

   assign bus.ready_tx = ready_q;
   assign bus.tx       = tx_q;
   assign bus.done_tx  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances covering no/even/odd parity and two stop bits, each frame
// compared clock by clock against a bit list built from the framing rules.
module tb_uart_tx;
   localparam int NI  = 4;
   localparam int DLY = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_a  [NI];
   logic       valid_a [NI];
   wire        ready_a [NI];
   wire        tx_a    [NI];
   wire        done_a  [NI];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Instance 0: none/1 stop, 1: even/1 stop, 2: odd/1 stop, 3: none/2 stop.
   function automatic int par_of(input int k);
      return (k == 1) ? 2 : ((k == 2) ? 1 : 0);
   endfunction

   function automatic int sb_of(input int k);
      return (k == 3) ? 2 : 1;
   endfunction

   generate
      for (genvar gi = 0; gi < NI; gi++) begin : g_dut
         uart_tx_if bus_i ();
         assign bus_i.data_tx  = data_a[gi];
         assign bus_i.valid_tx = valid_a[gi];
         assign ready_a[gi]    = bus_i.ready_tx;
         assign tx_a[gi]       = bus_i.tx;
         assign done_a[gi]     = bus_i.done_tx;

         uart_tx #(
            .SYS_CLK  (1_000_000),
            .BPS      (100_000),
            .PARITY   ((gi == 1) ? 2 : ((gi == 2) ? 1 : 0)),
            .STOP_BITS((gi == 3) ? 2 : 1)
         ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus_i)
         );
      end
   endgenerate

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sends byte b on instance k and checks every clock of the frame against the framing rules.
   task automatic send(input int k, input logic [7:0] b, input bit hold, input int spam_at,
                       input int abort_at, output int waited);
      bit exp_bits[12];
      int ones, nb, plen, sbits;
      ones  = 0;
      plen  = (par_of(k) != 0) ? 1 : 0;
      sbits = sb_of(k);
      for (int j = 0; j < 8; j++) ones += b[j];
      nb = 1 + 8 + plen + sbits;
      for (int j = 0; j < nb; j++) begin
         if (j == 0)                   exp_bits[j] = 1'b0;
         else if (j <= 8)              exp_bits[j] = b[j-1];
         else if (j == 9 && plen == 1) exp_bits[j] = (par_of(k) == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
         else                          exp_bits[j] = 1'b1;
      end

      waited = 0;
      while (ready_a[k] !== 1'b1 && waited < 200) begin
         @(posedge clk); #1;
         waited++;
      end
      chk($sformatf("ready_before_send[%0d]", k), 32'(ready_a[k]), 32'd1);
      data_a[k]  = b;
      valid_a[k] = 1'b1;
      @(posedge clk); #1;
      if (!hold) valid_a[k] = 1'b0;
      data_a[k] = 8'($urandom);
      $display("frame inst=%0d byte=%02h parity=%0d stop=%0d", k, b, par_of(k), sbits);

      for (int i = 0; i < nb * DLY; i++) begin
         if (i == spam_at) begin
            valid_a[k] = 1'b1;
            data_a[k]  = 8'hFF;
         end
         if (spam_at >= 0 && i == spam_at + 5) valid_a[k] = 1'b0;
         if (i == abort_at) begin
            rst = 1'b1;
            #1;
            chk($sformatf("abort_tx[%0d]", k), 32'(tx_a[k]), 32'd1);
            chk($sformatf("abort_ready[%0d]", k), 32'(ready_a[k]), 32'd1);
            @(posedge clk); #1;
            rst = 1'b0;
            chk($sformatf("abort_done[%0d]", k), 32'(done_a[k]), 32'd0);
            return;
         end
         chk($sformatf("tx[%0d] i=%0d", k, i), 32'(tx_a[k]), 32'(exp_bits[i / DLY]));
         chk($sformatf("busy_ready[%0d] i=%0d", k, i), 32'(ready_a[k]), 32'd0);
         chk($sformatf("busy_done[%0d] i=%0d", k, i), 32'(done_a[k]), 32'd0);
         @(posedge clk); #1;
      end
      chk($sformatf("end_done[%0d]", k), 32'(done_a[k]), 32'd1);
      chk($sformatf("end_ready[%0d]", k), 32'(ready_a[k]), 32'd1);
      chk($sformatf("end_tx[%0d]", k), 32'(tx_a[k]), 32'd1);
   endtask

   task automatic idle_check(input int k, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk); #1;
         chk($sformatf("idle_done[%0d]", k), 32'(done_a[k]), 32'd0);
         chk($sformatf("idle_tx[%0d]", k), 32'(tx_a[k]), 32'd1);
         chk($sformatf("idle_ready[%0d]", k), 32'(ready_a[k]), 32'd1);
      end
   endtask

   initial begin
      int w;
      int k;
      logic [7:0] b;
      for (int i = 0; i < NI; i++) begin
         data_a[i]  = 8'h00;
         valid_a[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("reset_tx[%0d]", i), 32'(tx_a[i]), 32'd1);
         chk($sformatf("reset_ready[%0d]", i), 32'(ready_a[i]), 32'd1);
         chk($sformatf("reset_done[%0d]", i), 32'(done_a[i]), 32'd0);
      end
      rst = 1'b0;
      idle_check(0, 2);

      // Directed cases from the framing rules.
      send(0, 8'hA5, 1'b0, -1, -1, w); idle_check(0, 2);
      send(1, 8'h07, 1'b0, -1, -1, w); idle_check(1, 1);
      send(2, 8'h07, 1'b0, -1, -1, w); idle_check(2, 1);
      send(3, 8'hFF, 1'b0, -1, -1, w); idle_check(3, 1);

      // Back-to-back with valid held high: exactly one idle clock between frames.
      send(0, 8'h55, 1'b1, -1, -1, w);
      data_a[0] = 8'hAA;
      send(0, 8'hAA, 1'b0, -1, -1, w);
      chk("b2b_wait", 32'(w), 32'd0);
      idle_check(0, 2);

      // Requests while busy are dropped and do not disturb the frame.
      send(0, 8'h00, 1'b0, 33, -1, w);
      idle_check(0, 3);

      // Reset during data bit 3 aborts the frame; the next byte goes out cleanly.
      send(0, 8'h5A, 1'b0, -1, 4 * DLY + 3, w);
      idle_check(0, 3);
      send(0, 8'h3C, 1'b0, -1, -1, w);
      idle_check(0, 1);

      // Random bytes on random parity/stop configurations.
      for (int r = 0; r < 12; r++) begin
         k = int'($urandom_range(0, NI - 1));
         b = 8'($urandom);
         send(k, b, 1'b0, ((r % 3) == 0) ? int'($urandom_range(5, 60)) : -1, -1, w);
         idle_check(k, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter that serialises one byte per request onto a single line as 8N1 by default, with optional parity and 2 stop bits.
It pairs with the existing UART receiver on the same board clock domain (25 MHz, 9600 bps default).
Upstream logic hands over a byte with a valid/ready handshake; the block drives the line and pulses done at frame end.

Parameters:
SYS_CLK, 25_000_000, system clock frequency in Hz
BPS, 9600, baud rate in bits per second
DELAY, SYS_CLK/BPS, clocks per bit (integer division); legal range 2..65535
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
data_tx  input  8  byte to send; sampled only on acceptance
valid_tx  input  1  request to send data_tx
ready_tx  output  1  high when idle and able to accept
tx  output  1  serial line; idles high
done_tx  output  1  one-clock pulse when the last stop bit completes

Behaviour:
- Reset (async, active-high): tx=1, ready_tx=1, done_tx=0, state=IDLE, counters=0.
- Reset asserted mid-frame aborts the frame; tx returns high immediately.
- Acceptance: valid_tx && ready_tx on a rising edge. At that edge:
  - data_tx is captured into a shift register;
  - parity is computed from the captured byte;
  - ready_tx falls.
- tx is registered. The start bit (0) appears on the clock edge after acceptance.
- States: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE.
- Baud counter (16 bit) runs 0..DELAY-1 in every non-IDLE state. Each bit is held for exactly DELAY clocks.
- State and bit advances occur when the counter equals DELAY-1.
- DATA sends bits LSB first, bit index 0..7. It leaves after bit 7 completes.
- Parity bit values:
  - even: tx = XOR of the 8 data bits;
  - odd: tx = inverted XOR of the 8 data bits.
- STOP: tx=1 for STOP_BITS*DELAY clocks.
- Frame end: on the edge ending the last stop bit, state->IDLE. In the following cycle, done_tx=1 for exactly one clock and ready_tx=1.
- Frame length from the start-bit edge to the IDLE edge: (1+8+P+STOP_BITS)*DELAY clocks, where P=1 if parity is enabled, else 0.
- Back-to-back: if valid_tx is high in the first IDLE cycle, the byte is accepted in that cycle. tx stays high for exactly 1 clock between frames.
- valid_tx while ready_tx=0 is ignored; there is no queue, and the in-flight frame is unaffected.
- data_tx changes after acceptance have no effect.
- In IDLE, tx=1 continuously and the counters are held at 0.

Test Plan:
- SYS_CLK=1_000_000, BPS=100_000 (DELAY=10), PARITY=0, STOP_BITS=1; send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit held 10 clocks; done_tx pulses once, 100 clocks after the start-bit edge; ready_tx high in the same cycle as the pulse.
- PARITY=2, send 0x07 -> parity bit 1. PARITY=1, send 0x07 -> parity bit 0. Frame is 110 clocks in both cases.
- valid_tx held high with 0x55 and then 0xAA -> two correct frames; exactly 1 idle-high clock between the 0x55 stop bit and the 0xAA start bit; two done_tx pulses.
- During the 0x00 frame, assert valid_tx with 0xFF for 5 cycles mid-DATA -> the 0x00 frame is unchanged and 0xFF is never sent.
- Assert rst during data bit 3 -> tx=1 and ready_tx=1 with no clock edge needed; no done_tx pulse; the next request 0x3C transmits correctly.
- STOP_BITS=2, send 0xFF -> stop level held high for 20 clocks before done_tx; total frame 110 clocks.
